clkdiv_sched: RTL
=================

CLKDIV_SCHED -- requirements
Module: clkdiv_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of divided-clock channels (2..8).
REQ-002 SHALL have parameter BASE_DIV, default 50, meaning clkin cycles per shared base tick (>=2; 50 MHz -> 1 MHz).
REQ-003 SHALL have parameter HW, default 16, meaning half-period register width in base ticks.
REQ-004 clkin  input  1  system clock; all state on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 clken  input  1  global run enable; low freezes prescaler and all channel counters.
REQ-007 cfg_valid  input  1  configuration request.
REQ-008 cfg_ready  output  1  scheduler can accept a configuration.
REQ-009 cfg_ch  input  clog2(NCH)  target channel index.
REQ-010 cfg_half  input  HW  channel half-period in base ticks.
REQ-011 cfg_en  input  1  channel enable written with the configuration.
REQ-012 clkout  output  NCH  divided clock per channel.
REQ-013 tick  output  NCH  one-clkin-cycle pulse coincident with each clkout toggle.

Function
REQ-014 SHALL contain one shared prescaler counting 0..BASE_DIV-1 while clken=1 and asserting internal base_tick for one cycle when it wraps from BASE_DIV-1 to 0.
REQ-015 SHALL hold per channel: en bit, half register (HW bits), counter (HW bits), clkout bit.
REQ-016 On base_tick, each enabled channel SHALL increment its counter; if counter+1 >= max(half,1), the counter clears, clkout toggles and tick pulses in that same registered update.
REQ-017 cfg_half=0 SHALL behave as 1 (toggle every base tick); no divide-by-zero or stall.
REQ-018 Disabled channels SHALL hold counter and clkout and never pulse tick.
REQ-019 clken=0 SHALL hold prescaler, all counters, all clkout; tick=0.
REQ-020 Config FSM states: IDLE (cfg_ready=1), APPLY (cfg_ready=0).
REQ-021 IDLE -> APPLY on cfg_valid & cfg_ready; cfg_ch/cfg_half/cfg_en captured that edge.
REQ-022 APPLY SHALL, in its single cycle, write en and half, clear counter and clkout of the captured channel to 0, then return to IDLE; sustained cfg_valid gives one accept per 2 cycles.
REQ-023 If a base_tick lands on the APPLY cycle, the configured channel SHALL take the config write (no tick, no toggle); other channels tick normally.
REQ-024 cfg_ch >= NCH SHALL be accepted and discarded, no state change.
REQ-025 Counter/half arithmetic SHALL be unsigned HW bits; comparison uses counter+1 in HW+1 bits, no wrap.

Reset
REQ-026 rst=0 SHALL asynchronously clear prescaler, all counters, half registers, en bits, clkout, tick; FSM to IDLE; cfg_ready=1 after deassertion.
REQ-027 Reset during APPLY SHALL abort the pending write; captured config is lost.
REQ-028 All channels SHALL be disabled out of reset until configured.

Structure
REQ-029 Shared package SHALL hold FSM state encoding (IDLE, APPLY) and default NCH/BASE_DIV/HW constants.
REQ-030 One sub-module, clkdiv_chan (one channel: en, half, counter, clkout, tick), SHALL be instantiated NCH times by generate; prescaler and FSM stay in the top.

Verification (bench: NCH=4, BASE_DIV=4, HW=8)
REQ-031 Reset release, clken=1, no config -> clkout=0000, tick=0000, cfg_ready=1 for 100 cycles.
REQ-032 Config ch0 half=3 en=1 -> clkout[0] toggles every 12 clkin cycles (period 24), tick[0] pulses once per toggle.
REQ-033 Config ch1 half=0 en=1 -> clkout[1] toggles every 4 clkin cycles, same as half=1.
REQ-034 Back-to-back cfg_valid for ch2, ch3 -> cfg_ready low one cycle after each accept; two accepts in 4 cycles; both channels run.
REQ-035 ch0 running, clken low 20 cycles -> clkout[0] and counter frozen; resume continues phase exactly.
REQ-036 Reconfigure ch0 on base_tick cycle while clkout[0]=1 -> clkout[0]=0, no tick[0] that cycle; rst pulse mid-APPLY -> all clear, cfg_ready=1.

Source files
------------

// File: rtl/clkdiv_sched_pkg.sv
// Shared constants and config FSM encoding for the clock-divider scheduler.
package clkdiv_sched_pkg;

  localparam int DEF_NCH      = 4;
  localparam int DEF_BASE_DIV = 50;
  localparam int DEF_HW       = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/clkdiv_sched_if.sv
// Configuration request bus: requester is master, scheduler is slave.
interface clkdiv_sched_if
  import clkdiv_sched_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int HW  = DEF_HW
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch;
  logic [HW-1:0] cfg_half;
  logic          cfg_en;

  modport master (
    output cfg_valid, cfg_ch, cfg_half, cfg_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_half, cfg_en,
    output cfg_ready
  );

endinterface

// File: rtl/clkdiv_sched_chan.sv
// One divided-clock channel: enable, half-period, tick counter and output phase.
module clkdiv_chan #(
  parameter int HW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          base_tick,
  input  logic          cfg_wr,
  input  logic [HW-1:0] cfg_half,
  input  logic          cfg_en,
  output logic          clkout,
  output logic          tick
);

  logic          en_q, en_d;
  logic [HW-1:0] half_q, half_d;
  logic [HW-1:0] cnt_q, cnt_d;
  logic          clkout_q, clkout_d;
  logic          tick_q, tick_d;
  logic [HW:0]   cnt_inc;
  logic [HW:0]   half_eff;

  // A config write owns the channel for that cycle, even if a base tick lands on it.
  always_comb begin
    en_d     = en_q;
    half_d   = half_q;
    cnt_d    = cnt_q;
    clkout_d = clkout_q;
    tick_d   = 1'b0;
    cnt_inc  = {1'b0, cnt_q} + (HW+1)'(1);
    half_eff = (half_q == '0) ? (HW+1)'(1) : {1'b0, half_q};
    if (cfg_wr) begin
      en_d     = cfg_en;
      half_d   = cfg_half;
      cnt_d    = '0;
      clkout_d = 1'b0;
    end else if (base_tick && en_q) begin
      if (cnt_inc >= half_eff) begin
        cnt_d    = '0;
        clkout_d = ~clkout_q;
        tick_d   = 1'b1;
      end else begin
        cnt_d = cnt_inc[HW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      half_q   <= '0;
      cnt_q    <= '0;
      clkout_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      en_q     <= en_d;
      half_q   <= half_d;
      cnt_q    <= cnt_d;
      clkout_q <= clkout_d;
      tick_q   <= tick_d;
    end
  end

  assign clkout = clkout_q;
  assign tick   = tick_q;

endmodule

// File: rtl/clkdiv_sched.sv
// Multi-channel clock divider: shared prescaler, config FSM, NCH channel instances.
module clkdiv_sched
  import clkdiv_sched_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int BASE_DIV = DEF_BASE_DIV,
  parameter int HW       = DEF_HW
) (
  input  logic            clkin,
  input  logic            rst,
  input  logic            clken,
  clkdiv_sched_if.slave   cfg,
  output logic [NCH-1:0]  clkout,
  output logic [NCH-1:0]  tick
);

  localparam int            PW       = $clog2(BASE_DIV);
  localparam int            CW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(BASE_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          base_tick;
  cfg_state_e    state_q, state_d;
  logic [CW-1:0] cap_ch_q, cap_ch_d;
  logic [HW-1:0] cap_half_q, cap_half_d;
  logic          cap_en_q, cap_en_d;

  always_comb begin
    pre_d     = pre_q;
    base_tick = 1'b0;
    if (clken) begin
      if (pre_q == PRE_LAST) begin
        pre_d     = '0;
        base_tick = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cap_ch_d   = cap_ch_q;
    cap_half_d = cap_half_q;
    cap_en_d   = cap_en_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg.cfg_valid) begin
          state_d    = ST_APPLY;
          cap_ch_d   = cfg.cfg_ch;
          cap_half_d = cfg.cfg_half;
          cap_en_d   = cfg.cfg_en;
        end
      end
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      pre_q      <= '0;
      state_q    <= ST_IDLE;
      cap_ch_q   <= '0;
      cap_half_q <= '0;
      cap_en_q   <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      state_q    <= state_d;
      cap_ch_q   <= cap_ch_d;
      cap_half_q <= cap_half_d;
      cap_en_q   <= cap_en_d;
    end
  end

  assign cfg.cfg_ready = (state_q == ST_IDLE);

  // Out-of-range channel indices match no instance, so the write is simply dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clkdiv_chan #(.HW(HW)) u_chan (
      .clk       (clkin),
      .rst_n     (rst),
      .base_tick (base_tick),
      .cfg_wr    ((state_q == ST_APPLY) && (cap_ch_q == CW'(i))),
      .cfg_half  (cap_half_q),
      .cfg_en    (cap_en_q),
      .clkout    (clkout[i]),
      .tick      (tick[i])
    );
  end

endmodule
